// File: rtl/vote_session_if.sv
// vote_session_if: booth/core signal bundle for the ballot-session controller
interface vote_session_if;
  logic       open_req_i;
  logic       close_req_i;
  logic       voter_auth_i;
  logic       btn_a_i;
  logic       btn_b_i;
  logic       btn_c_i;
  logic       valid_vote_i;
  logic       vote_a_o;
  logic       vote_b_o;
  logic       vote_c_o;
  logic       enable_o;
  logic       admin_mode_o;
  logic [2:0] state_o;
  logic       ballot_done_o;
  logic       reject_o;
  logic       timeout_o;
  logic       ack_err_o;
  logic [7:0] voters_served_o;
  modport slave (
    input  open_req_i, close_req_i, voter_auth_i, btn_a_i, btn_b_i, btn_c_i, valid_vote_i,
    output vote_a_o, vote_b_o, vote_c_o, enable_o, admin_mode_o, state_o,
           ballot_done_o, reject_o, timeout_o, ack_err_o, voters_served_o
  );
  modport master (
    output open_req_i, close_req_i, voter_auth_i, btn_a_i, btn_b_i, btn_c_i, valid_vote_i,
    input  vote_a_o, vote_b_o, vote_c_o, enable_o, admin_mode_o, state_o,
           ballot_done_o, reject_o, timeout_o, ack_err_o, voters_served_o
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: one-vote-per-voter ballot session controller in front of the counter core
module vote_session_ctrl #(
  parameter int TIMEOUT    = 1000,
  parameter int COOLDOWN   = 16,
  parameter int ACK_WINDOW = 4
) (
  input logic          clk,
  input logic          rst,
  vote_session_if.slave bus
);
  typedef enum logic [2:0] {
    CLOSED   = 3'd0,
    READY    = 3'd1,
    ARMED    = 3'd2,
    COMMIT   = 3'd3,
    WAIT_ACK = 3'd4,
    LOCK     = 3'd5,
    RESULTS  = 3'd6
  } state_t;
  localparam int M1 = TIMEOUT > COOLDOWN ? TIMEOUT : COOLDOWN;
  localparam int CW = $clog2((M1 > ACK_WINDOW ? M1 : ACK_WINDOW) + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic          auth_q;
  logic [2:0]    cand_q, cand_d;
  logic          close_pend_q, close_pend_d;
  logic [2:0]    vote_q, vote_d;
  logic          done_q, done_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic          ack_err_q, ack_err_d;
  logic [7:0]    served_q, served_d;
  logic          enable_q, enable_d;
  logic          admin_q, admin_d;
  logic [2:0]    btn_edge;
  logic          single, multi, auth_edge, in_ballot;
  assign btn_edge  = sync2_q & ~prev_q;
  assign single    = $onehot(btn_edge);
  assign multi     = |btn_edge && !single;
  assign auth_edge = bus.voter_auth_i & ~auth_q;
  assign in_ballot = state_q inside {ARMED, COMMIT, WAIT_ACK, LOCK};
  // next-state, pulse and bookkeeping decode; one shared counter restarts on every state change
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    done_d       = 1'b0;
    reject_d     = 1'b0;
    timeout_d    = 1'b0;
    ack_err_d    = ack_err_q;
    served_d     = served_q;
    close_pend_d = close_pend_q | (in_ballot & bus.close_req_i);
    case (state_q)
      CLOSED:   state_d = bus.open_req_i ? READY : CLOSED;
      READY:    state_d = (bus.close_req_i || close_pend_q) ? RESULTS : auth_edge ? ARMED : READY;
      ARMED: begin
        reject_d = multi;
        if (single) begin
          state_d = COMMIT;
          cand_d  = btn_edge;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          state_d   = READY;
          timeout_d = 1'b1;
        end
      end
      COMMIT:   state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.valid_vote_i) begin
          state_d  = LOCK;
          done_d   = 1'b1;
          served_d = served_q == 8'hff ? served_q : served_q + 8'd1;
        end else if (cnt_q >= CW'(ACK_WINDOW - 1)) begin
          state_d   = READY;
          ack_err_d = 1'b1;
        end
      end
      LOCK:     state_d = cnt_q >= CW'(COOLDOWN - 1) ? READY : LOCK;
      RESULTS:  state_d = RESULTS;
      default:  state_d = CLOSED;
    endcase
    cnt_d    = state_d != state_q ? '0 : cnt_q + CW'(1);
    vote_d   = state_d == COMMIT ? cand_d : 3'b000;
    enable_d = state_d inside {ARMED, COMMIT, WAIT_ACK};
    admin_d  = state_d == RESULTS;
  end
  // state, synchronizers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLOSED;
      cnt_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      auth_q       <= 1'b0;
      cand_q       <= '0;
      close_pend_q <= 1'b0;
      vote_q       <= '0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      ack_err_q    <= 1'b0;
      served_q     <= '0;
      enable_q     <= 1'b0;
      admin_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= {bus.btn_a_i, bus.btn_b_i, bus.btn_c_i};
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      auth_q       <= bus.voter_auth_i;
      cand_q       <= cand_d;
      close_pend_q <= close_pend_d;
      vote_q       <= vote_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
      ack_err_q    <= ack_err_d;
      served_q     <= served_d;
      enable_q     <= enable_d;
      admin_q      <= admin_d;
    end
  end
  assign bus.vote_a_o        = vote_q[2];
  assign bus.vote_b_o        = vote_q[1];
  assign bus.vote_c_o        = vote_q[0];
  assign bus.enable_o        = enable_q;
  assign bus.admin_mode_o    = admin_q;
  assign bus.state_o         = state_q;
  assign bus.ballot_done_o   = done_q;
  assign bus.reject_o        = reject_q;
  assign bus.timeout_o       = timeout_q;
  assign bus.ack_err_o       = ack_err_q;
  assign bus.voters_served_o = served_q;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: table-driven and directed checks of the ballot-session controller
module tb_vote_session_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vote_session_if bus();
  vote_session_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0]  in;
    int          n;
    logic [19:0] exp;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [19:0] outs();
    return {bus.state_o, bus.vote_a_o, bus.vote_b_o, bus.vote_c_o, bus.enable_o, bus.admin_mode_o,
            bus.ballot_done_o, bus.reject_o, bus.timeout_o, bus.ack_err_o, bus.voters_served_o};
  endfunction
  function automatic vec_t mk(logic [6:0] in, int n, logic [2:0] st, logic [2:0] vote, logic [5:0] flags, logic [7:0] served);
    vec_t v;
    v.in  = in;
    v.n   = n;
    v.exp = {st, vote, flags, served};
    return v;
  endfunction
  task automatic drive(input logic [6:0] in);
    {bus.open_req_i, bus.close_req_i, bus.voter_auth_i, bus.btn_a_i, bus.btn_b_i, bus.btn_c_i, bus.valid_vote_i} = in;
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic ballot_a();
    drive(7'b0010000);
    step();
    drive(7'b0001000);
    step(3);
    drive(7'b0000000);
    step();
    drive(7'b0000001);
    step();
    drive(7'b0000000);
    step(16);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
  initial begin
    // inputs {open,close,auth,a,b,c,valid}; flags {en,adm,done,rej,to,aerr}
    vecs.push_back(mk(7'b1000000,  1, 3'd1, 3'b000, 6'b000000, 8'd0));
    vecs.push_back(mk(7'b0010000,  1, 3'd2, 3'b000, 6'b100000, 8'd0));
    vecs.push_back(mk(7'b0000100,  1, 3'd2, 3'b000, 6'b100000, 8'd0));
    vecs.push_back(mk(7'b0000100,  1, 3'd2, 3'b000, 6'b100000, 8'd0));
    vecs.push_back(mk(7'b0000100,  1, 3'd3, 3'b010, 6'b100000, 8'd0));
    vecs.push_back(mk(7'b0000000,  1, 3'd4, 3'b000, 6'b100000, 8'd0));
    vecs.push_back(mk(7'b0000001,  1, 3'd5, 3'b000, 6'b001000, 8'd1));
    vecs.push_back(mk(7'b0000000,  1, 3'd5, 3'b000, 6'b000000, 8'd1));
    vecs.push_back(mk(7'b0000000, 14, 3'd5, 3'b000, 6'b000000, 8'd1));
    vecs.push_back(mk(7'b0000000,  1, 3'd1, 3'b000, 6'b000000, 8'd1));
    vecs.push_back(mk(7'b0010000,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001010,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001010,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001010,  1, 3'd2, 3'b000, 6'b100100, 8'd1));
    vecs.push_back(mk(7'b0001010,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0000000,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0000000,  2, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001000,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001000,  1, 3'd2, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0001000,  1, 3'd3, 3'b100, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0000000,  1, 3'd4, 3'b000, 6'b100000, 8'd1));
    vecs.push_back(mk(7'b0000001,  1, 3'd5, 3'b000, 6'b001000, 8'd2));
    vecs.push_back(mk(7'b0000000, 16, 3'd1, 3'b000, 6'b000000, 8'd2));
    drive(7'b0000000);
    step(2);
    rst = 1'b0;
    chk("reset_outs", 32'(outs()), 32'h0);
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      step(vecs[i].n);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    drive(7'b0010000);
    step();
    drive(7'b0000000);
    chk("to_armed", 32'(bus.state_o), 32'd2);
    step(999);
    chk("to_pre", 32'({bus.state_o, bus.timeout_o}), 32'({3'd2, 1'b0}));
    step();
    chk("to_fire", 32'(outs()), 32'({3'd1, 3'b000, 6'b000010, 8'd2}));
    step();
    chk("to_pulse_end", 32'(bus.timeout_o), 32'd0);
    drive(7'b0010000);
    step();
    drive(7'b0000010);
    step(3);
    chk("ack_commit_c", 32'(outs()), 32'({3'd3, 3'b001, 6'b100000, 8'd2}));
    drive(7'b0000000);
    step(4);
    chk("ack_wait4", 32'({bus.state_o, bus.ack_err_o}), 32'({3'd4, 1'b0}));
    step();
    chk("ack_err_set", 32'(outs()), 32'({3'd1, 3'b000, 6'b000001, 8'd2}));
    drive(7'b0010000);
    step();
    drive(7'b0001000);
    step(3);
    drive(7'b0000000);
    step();
    drive(7'b0000001);
    step();
    chk("ack_err_sticky", 32'(outs()), 32'({3'd5, 3'b000, 6'b001001, 8'd3}));
    drive(7'b0000000);
    step(16);
    chk("ack_err_ready", 32'({bus.state_o, bus.ack_err_o}), 32'({3'd1, 1'b1}));
    drive(7'b0010000);
    step();
    drive(7'b0000100);
    step(3);
    drive(7'b0000000);
    step();
    drive(7'b0100001);
    step();
    chk("close_done", 32'(outs()), 32'({3'd5, 3'b000, 6'b001001, 8'd4}));
    drive(7'b0000000);
    step(15);
    chk("close_lock", 32'(bus.state_o), 32'd5);
    step();
    chk("close_ready", 32'(bus.state_o), 32'd1);
    step();
    chk("results", 32'(outs()), 32'({3'd6, 3'b000, 6'b010001, 8'd4}));
    drive(7'b1010100);
    step(3);
    chk("results_hold", 32'(outs()), 32'({3'd6, 3'b000, 6'b010001, 8'd4}));
    drive(7'b0000000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_from_results", 32'(outs()), 32'h0);
    drive(7'b1000000);
    step();
    drive(7'b0000000);
    repeat (255) ballot_a();
    chk("served_255", 32'(bus.voters_served_o), 32'd255);
    ballot_a();
    chk("served_sat", 32'({bus.state_o, bus.voters_served_o}), 32'({3'd1, 8'd255}));
    drive(7'b0010000);
    step();
    drive(7'b0000100);
    step(2);
    chk("mid_armed", 32'(bus.state_o), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(7'b0000000);
    chk("mid_reset", 32'(outs()), 32'h0);
    step();
    chk("mid_reset_quiet", 32'(outs()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
